// File: rtl/wb_arb2_pkg.sv
// rtl/wb_arb2_pkg.sv - shared constants for the two-master Wishbone arbiter
//
// Purpose : state encoding, one-hot grant constants and a saturating
//           counter helper shared by wb_arb2 and wb_arb_wdog.
// Ports   : none (package).

package wb_arb2_pkg;

    // Arbiter FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    // One-hot grant vector values presented on gnt_o.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // 8-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wb_arb_wdog.sv
// rtl/wb_arb_wdog.sv - per-transfer ack watchdog with saturating timeout count
//
// Purpose : counts consecutive strobe cycles without a slave response and
//           raises a one-cycle expiry pulse when the limit is reached.
// Ports   :
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   i_stb     in   strobe currently presented to the slave
//   i_ack     in   slave ack
//   i_err     in   slave err
//   o_expire  out  combinational expiry pulse (stb held TIMEOUT cycles, no ack)
//   o_tmo_cnt out  saturating count of expiries

module wb_arb_wdog
    import wb_arb2_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_stb,
    input  logic       i_ack,
    input  logic       i_err,
    output logic       o_expire,
    output logic [7:0] o_tmo_cnt
);

    localparam int             CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_wdc;
    logic [7:0]    r_tmo_cnt;
    logic          w_wait;

    // A strobe cycle that got neither ack nor err is a cycle spent waiting.
    assign w_wait = i_stb & ~i_ack & ~i_err;

    // Expiry fires on the TIMEOUT-th waiting cycle; an ack in that same
    // cycle completes the transfer normally and suppresses the expiry.
    assign o_expire  = i_stb & ~i_ack & (r_wdc == LIMIT);
    assign o_tmo_cnt = r_tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdc     <= '0;
            r_tmo_cnt <= 8'd0;
        end else begin
            if (o_expire || !w_wait) begin
                r_wdc <= '0;
            end else begin
                r_wdc <= r_wdc + 1'b1;
            end
            if (o_expire) begin
                r_tmo_cnt <= sat_inc8(r_tmo_cnt);
            end
        end
    end

endmodule

// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - two-master one-slave Wishbone arbiter with round-robin grant
//
// Purpose : lets two Wishbone masters share one slave. Grant is round-robin
//           on ties, locked for the whole cyc period, and a watchdog turns a
//           missing slave ack into an error response.
// Ports   :
//   wb_clk_i            in   clock
//   wb_rst_i            in   asynchronous active-low reset
//   m0_* / m1_* (_i)    in   master request: adr, dat, sel, we, cyc, stb
//   m0_* / m1_* (_o)    out  master response: dat, ack, err
//   s_*_o               out  slave request: adr, dat, sel, we, cyc, stb
//   s_dat_i/ack_i/err_i in   slave response
//   gnt_o               out  one-hot grant (01 = m0, 10 = m1, 00 = idle)
//   tmo_cnt_o           out  saturating count of watchdog timeouts

module wb_arb2
    import wb_arb2_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [SW-1:0] m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [SW-1:0] m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic [SW-1:0] s_sel_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,

    output logic [1:0]    gnt_o,
    output logic [7:0]    tmo_cnt_o
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_last;       // last-granted master: 0 = m0, 1 = m1
    logic       w_last_nxt;
    logic       w_g0;
    logic       w_g1;
    logic       w_expire;
    logic       w_err;

    assign w_g0 = (r_state == ST_GNT0);
    assign w_g1 = (r_state == ST_GNT1);

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    // Tie goes to whichever master was not served last.
                    w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = ST_GNT0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (w_expire) begin
                    // Timeout always drops back to IDLE so the slave sees
                    // cyc deasserted for at least one cycle.
                    w_last_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (!m0_cyc_i) begin
                    w_last_nxt  = 1'b0;
                    w_state_nxt = m1_cyc_i ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (w_expire) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!m1_cyc_i) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = m0_cyc_i ? ST_GNT0 : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request routing. Control strobes are qualified by grant, so IDLE
    // (including reset) forwards nothing. Address/data/select default to
    // m0 but are forced to zero while reset is held.
    // ------------------------------------------------------------------
    assign s_cyc_o = (w_g0 & m0_cyc_i) | (w_g1 & m1_cyc_i);
    assign s_stb_o = (w_g0 & m0_stb_i) | (w_g1 & m1_stb_i);
    assign s_we_o  = (w_g0 & m0_we_i)  | (w_g1 & m1_we_i);

    assign s_adr_o = !wb_rst_i ? '0 : (w_g1 ? m1_adr_i : m0_adr_i);
    assign s_dat_o = !wb_rst_i ? '0 : (w_g1 ? m1_dat_i : m0_dat_i);
    assign s_sel_o = !wb_rst_i ? '0 : (w_g1 ? m1_sel_i : m0_sel_i);

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    assign m0_dat_o = !wb_rst_i ? '0 : s_dat_i;
    assign m1_dat_o = !wb_rst_i ? '0 : s_dat_i;

    // A watchdog expiry looks like a slave error to the granted master.
    assign w_err = s_err_i | w_expire;

    assign m0_ack_o = s_ack_i & w_g0 & m0_stb_i;
    assign m1_ack_o = s_ack_i & w_g1 & m1_stb_i;
    assign m0_err_o = w_err   & w_g0 & m0_stb_i;
    assign m1_err_o = w_err   & w_g1 & m1_stb_i;

    assign gnt_o = w_g0 ? GNT_M0 : (w_g1 ? GNT_M1 : GNT_NONE);

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    wb_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_i),
        .i_stb     (s_stb_o),
        .i_ack     (s_ack_i),
        .i_err     (s_err_i),
        .o_expire  (w_expire),
        .o_tmo_cnt (tmo_cnt_o)
    );

endmodule

// File: doc/wb_arb2.md
Name: wb_arb2

Overview:
- Two-master, one-slave Wishbone arbiter.
- Lets the CPU data port (m0) and instruction port (m1) share one Wishbone slave, such as a unified BRAM or the peripheral decoder, without going through the full crossbar.
- Uses round-robin grant. The grant is locked for the whole cyc period.
- A per-transfer watchdog converts a missing slave ack into an error response, so the CPU never hangs.

Parameters:
- AW, 32, address width
- DW, 32, data width
- SW, 4, byte-select width (DW/8)
- TIMEOUT, 255, cycles of stb without ack before error; must be ≥2, counter width $clog2(TIMEOUT+1)

Ports:
- wb_clk_i  in  1  single clock for the block
- wb_rst_i  in  1  asynchronous, active-low reset (0 = reset)
- m0_adr_i/m0_dat_i/m0_sel_i/m0_we_i/m0_cyc_i/m0_stb_i  in  AW/DW/SW/1/1/1  master 0 request
- m0_dat_o/m0_ack_o/m0_err_o  out  DW/1/1  master 0 response
- m1_adr_i/m1_dat_i/m1_sel_i/m1_we_i/m1_cyc_i/m1_stb_i  in  AW/DW/SW/1/1/1  master 1 request
- m1_dat_o/m1_ack_o/m1_err_o  out  DW/1/1  master 1 response
- s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o  out  AW/DW/SW/1/1/1  slave request
- s_dat_i/s_ack_i/s_err_i  in  DW/1/1  slave response
- gnt_o  out  2  one-hot current grant: 01 = m0, 10 = m1, 00 = idle
- tmo_cnt_o  out  8  saturating count of watchdog timeouts

Behaviour:
- State register: IDLE, GNT0, GNT1. Other registers: last-granted pointer `last`, watchdog counter `wdc`, `tmo_cnt_o`.
- Reset values: state=IDLE, last=1 (m0 wins the first tie), wdc=0, tmo_cnt_o=0.
- While in reset, all outputs are 0 and every master ack/err output is 0.

State transitions:
- IDLE, request seen: if only m0_cyc_i, go to GNT0. If only m1_cyc_i, go to GNT1. If both, grant the master that is not `last`.
- Arbitration latency is 1 cycle: cyc seen in IDLE at cycle N gives grant (and s_cyc_o) at N+1. No request is forwarded while in IDLE.
- GNTx is held while mx_cyc_i=1, including back-to-back stb/ack beats.
- GNTx when mx_cyc_i=0: set last=x. Then go to GNTy if the other master's cyc is high, otherwise IDLE. Switching takes no idle cycle.

Routing (combinational from the state register):
- s_* request signals copy the granted master.
- In IDLE, s_cyc_o=s_stb_o=s_we_o=0. s_adr_o, s_dat_o and s_sel_o copy m0.
- s_dat_i fans out to both mx_dat_o.
- ack and err go only to the granted master: mx_ack_o = s_ack_i & grant_x & mx_stb_i, and likewise for err.

Watchdog:
- wdc increments each cycle that s_stb_o=1 and s_ack_i=0 and s_err_i=0.
- wdc clears on ack, on err, or when s_stb_o=0.
- When wdc==TIMEOUT-1 and no ack arrives that cycle:
  - the granted master gets mx_err_o=1 for exactly that cycle;
  - s_cyc_o/s_stb_o are forced to 0 in the following cycle;
  - tmo_cnt_o increments, saturating at 255;
  - state goes to IDLE and last=x, whether or not mx_cyc_i is still high.
- An ack arriving in the same cycle as expiry wins: normal ack, no err.

Boundary conditions:
- A master dropping cyc mid-transfer without ack is legal. The release is treated as above.
- The ungranted master sees ack=err=0 and must hold its signals steady.
- Reset asserted mid-transfer returns to IDLE immediately; the slave sees cyc drop asynchronously.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and GNT_M0/GNT_M1 one-hot constants.
- One natural sub-module: wb_arb_wdog, containing the watchdog counter, expiry pulse and saturating tmo_cnt_o.
- Muxing and the FSM stay in wb_arb2.

Test Plan:
- Single m0 read, slave acks 2 cycles after stb:
  - s_cyc_o rises 1 cycle after m0_cyc_i;
  - m0_ack_o pulses with s_ack_i;
  - m0_dat_o=0xDEADBEEF;
  - gnt_o=01, then 00 after cyc drops.
- Both cyc high in the same cycle straight after reset:
  - m0 is granted first;
  - on m0 release, m1 is granted the next cycle with no IDLE cycle;
  - on the next tie, m1 loses.
- m0 holds cyc over 4 back-to-back acked beats while m1 requests:
  - grant stays 01 for all 4 beats;
  - m1_ack_o stays 0 throughout;
  - m1 is granted after m0 cyc drops.
- Slave never acks, TIMEOUT=8:
  - m1_err_o pulses exactly on the 8th stb cycle;
  - s_cyc_o is 0 on the next cycle;
  - tmo_cnt_o=1;
  - state returns to IDLE.
- Ack on the exact expiry cycle: m0_ack_o=1, m0_err_o=0, tmo_cnt_o unchanged.
- wb_rst_i pulled low mid-transfer:
  - s_cyc_o=0 and gnt_o=00 without waiting for a clock;
  - after release, a tie is granted to m0.
